fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side drain engine for the team's FIFOs; runs entirely in the read clock domain.
- Issues pop requests on the FIFO read port and absorbs the port's one-cycle read latency (data returns the cycle after a pop).
- Presents a clean valid/ready stream downstream with no bubbles at full rate.
- Sits between the FIFO read port and any consumer (bus master, UART TX, DMA) that needs back-pressure without losing data.

Parameters:
- DATA_WIDTH, 8, width of data words.
- BUF_DEPTH, 4, skid-buffer entries; power of two, minimum 2. Values of 3 or more give one word per cycle sustained.
- CNT_WIDTH, 3, width of occupancy output; must satisfy 2^CNT_WIDTH > BUF_DEPTH.

Ports:
- rd_clk  input  1  read-domain clock; all logic on its rising edge.
- rd_rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, rd_clk domain.
- fifo_rd_ready  output  1  pop request to FIFO; one word popped per cycle high.
- fifo_rd_valid  input  1  FIFO read data valid; expected exactly one cycle after a pop.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, qualified by fifo_rd_valid.
- out_valid  output  1  downstream data valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  downstream data.
- buf_count  output  CNT_WIDTH  number of words held in the skid buffer.
- err_unexp  output  1  sticky flag: fifo_rd_valid seen with no pop outstanding.

Behaviour:
- Reset values: rd_rst asserted asynchronously clears the following, overriding any activity in progress:
  - fifo_rd_ready=0, out_valid=0, out_data=0, buf_count=0, err_unexp=0.
  - in_flight=0, head and tail pointers=0.
  - A pop outstanding at reset is discarded; its returning word is ignored.
- Internal state:
  - Circular buffer of BUF_DEPTH entries with head and tail pointers of log2(BUF_DEPTH) bits; both wrap naturally.
  - Registered count cnt, range 0..BUF_DEPTH.
  - Registered in_flight bit: set the cycle after a pop, cleared otherwise.
- Pop rule:
  - fifo_rd_ready = !rd_rst && !fifo_empty && (cnt + in_flight < BUF_DEPTH).
  - Uses registered state only; it never depends combinationally on out_ready.
  - The ≤ BUF_DEPTH guarantee counts the in-flight word, so the buffer can never overflow.
- Fill:
  - On fifo_rd_valid && in_flight, fifo_rd_data is written to buf[tail] and tail increments.
  - in_flight_next = fifo_rd_ready.
- Drain:
  - out_valid = (cnt != 0); out_data = buf[head], driven combinationally from the buffer.
  - On out_valid && out_ready, head increments.
  - out_data is held stable while out_valid && !out_ready.
- Count update:
  - cnt increments on fill only, decrements on drain only, and is unchanged when fill and drain happen in the same cycle.
  - buf_count = cnt.
- Latency: pop in cycle t → FIFO data in t+1 → out_valid in t+2, provided the buffer was empty.
- Throughput: with BUF_DEPTH ≥ 3, out_ready held high and the FIFO non-empty, out_valid stays high every cycle once primed.
- Full buffer: when cnt + in_flight = BUF_DEPTH, no pop is issued. The FIFO keeps its data and nothing is lost.
- Empty FIFO: no pop is issued and out_valid drops once the buffer drains. There are no spurious pops.
- Unexpected valid: fifo_rd_valid while in_flight=0 → word dropped, err_unexp set. err_unexp clears only on rd_rst.
- Ordering: words are delivered strictly in pop order, with no duplication or loss.

Test Plan:
- Reset and hold:
  - Stimulus: assert rd_rst mid-stream, with in_flight=1 and cnt=2.
  - Required: all outputs go to 0 immediately without a clock edge. After release, the first fifo_rd_valid (the stale return) sets err_unexp=1 and is not output.
- Basic latency:
  - Stimulus: FIFO holds 0xA5, out_ready=1.
  - Required: fifo_rd_ready high in cycle 1; out_valid=1 with out_data=0xA5 in cycle 3; fifo_rd_ready low afterwards because fifo_empty=1.
- Streaming:
  - Stimulus: BUF_DEPTH=4, FIFO preloaded with 0x00..0x0F, out_ready=1.
  - Required: after a 2-cycle prime, 16 consecutive out_valid cycles carrying 0x00..0x0F in order.
- Back-pressure:
  - Stimulus: out_ready=0 with the FIFO holding 10 words.
  - Required: exactly 4 pops total; buf_count=4; fifo_rd_ready=0 thereafter; out_data steady at word 0.
  - Then: raising out_ready delivers all 10 words in order with no loss.
- Simultaneous fill and drain:
  - Stimulus: cnt=2, a fill and out_ready=1 in the same cycle.
  - Required: buf_count stays 2; pointers wrap correctly past entry 3 (check head 3→0).
- Intermittent empty:
  - Stimulus: fifo_empty toggled every other cycle, random out_ready.
  - Required: no pop is issued while fifo_empty=1; output sequence equals input sequence; err_unexp stays 0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-port drain engine with skid buffer and valid/ready output
//
// Pops the FIFO whenever the skid buffer has room for every word already
// committed to it (stored words plus the one still in flight). The engine
// captures read data one cycle after the pop and presents the buffered words
// downstream as a valid/ready stream.
//
// Ports:
//   rd_clk         read-domain clock, all state on its rising edge
//   rd_rst         asynchronous active-high reset
//   fifo_empty     FIFO empty flag
//   fifo_rd_ready  pop request, one word popped per cycle high
//   fifo_rd_valid  FIFO read data valid, one cycle after a pop
//   fifo_rd_data   FIFO read data
//   out_valid      downstream data valid
//   out_ready      downstream accept
//   out_data       downstream data (buffer head)
//   buf_count      words held in the skid buffer
//   err_unexp      sticky: read data arrived with no pop outstanding
`timescale 1ns/1ps
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_ready,
    input  logic                  fifo_rd_valid,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  buf_count,
    output logic                  err_unexp
);

    localparam int PTR_WIDTH = $clog2(BUF_DEPTH);
    localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH+1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  in_flight;
    logic                  err_q;

    logic                  fill;
    logic                  drain;
    logic                  unexp;
    logic [CNT_WIDTH:0]    committed;

    // Space check counts the in-flight word so a returning word always has
    // a free entry; the decision uses registered state only, never out_ready.
    assign committed     = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, in_flight};
    assign fifo_rd_ready = !rd_rst && !fifo_empty && (committed < DEPTH_C);

    assign fill  = fifo_rd_valid && in_flight;
    assign unexp = fifo_rd_valid && !in_flight;

    assign out_valid = (cnt != '0);
    assign drain     = out_valid && out_ready;

    // Gated so the output reads zero while empty (including straight out of
    // reset) without having to clear the storage array.
    assign out_data  = out_valid ? buf_mem[head] : '0;
    assign buf_count = cnt;
    assign err_unexp = err_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            in_flight <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            in_flight <= fifo_rd_ready;

            if (fill) begin
                tail <= tail + PTR_WIDTH'(1);
            end
            if (drain) begin
                head <= head + PTR_WIDTH'(1);
            end

            if (fill && !drain) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end else if (drain && !fill) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end

            // A return with nothing outstanding (e.g. a pop cut off by reset)
            // is dropped and remembered until the next reset.
            if (unexp) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; only entries between head and tail are ever read.
    always_ff @(posedge rd_clk) begin
        if (fill) begin
            buf_mem[tail] <= fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BD = 4;
    localparam int CW = 3;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          fifo_empty;
    logic          fifo_rd_ready;
    logic          fifo_rd_valid;
    logic [DW-1:0] fifo_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] buf_count;
    logic          err_unexp;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_ready (fifo_rd_ready),
        .fifo_rd_valid (fifo_rd_valid),
        .fifo_rd_data  (fifo_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .buf_count     (buf_count),
        .err_unexp     (err_unexp)
    );

    // Reference model: words sitting in the source FIFO, and words popped
    // but not yet delivered. Delivery order must equal pop order.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int n_beats  = 0;

    bit            hold_pending = 1'b0;
    logic [DW-1:0] hold_data    = '0;
    bit            tog_mode     = 1'b0;
    bit            tog_phase    = 1'b0;
    bit            rand_ready   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
    endtask

    task automatic apply_empty();
        fifo_empty = (src_q.size() == 0) || (tog_mode && tog_phase);
        #1;
    endtask

    // One clock: sample at the falling edge, let the DUT clock, then model
    // the FIFO returning the popped word one cycle later.
    task automatic step();
        logic          pop_now;
        logic [DW-1:0] w;
        w = '0;
        @(negedge rd_clk);
        pop_now = fifo_rd_ready;
        if (pop_now) begin
            check("pop_while_empty", 32'(!fifo_empty && (src_q.size() != 0)), 32'd1);
            n_pops++;
            if (src_q.size() != 0) begin
                w = src_q.pop_front();
                exp_q.push_back(w);
            end
        end
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(hold_data));
        end
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        if (out_valid && out_ready) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                check("spurious_beat", 32'(out_valid), 32'd0);
            end else begin
                check("beat_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        @(posedge rd_clk);
        #1;
        fifo_rd_valid = pop_now;
        fifo_rd_data  = pop_now ? w : DW'($urandom);
        tog_phase     = !tog_phase;
        if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end
        fifo_empty = (src_q.size() == 0) || (tog_mode && tog_phase);
        #1;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !out_valid && !fifo_rd_valid) begin
                break;
            end
            step();
        end
    endtask

    initial begin
        int            base;
        logic [DW-1:0] first_w;
        logic [DW-1:0] second_w;
        logic [DW-1:0] stale;

        rd_rst        = 1'b1;
        fifo_empty    = 1'b1;
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = '0;
        out_ready     = 1'b0;
        #2;
        check("rst_rd_ready", 32'(fifo_rd_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_buf_count", 32'(buf_count), 32'd0);
        check("rst_err", 32'(err_unexp), 32'd0);
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        #1;

        // Basic latency: single word 0xA5
        out_ready = 1'b1;
        push_word(8'hA5);
        apply_empty();
        check("lat_pop_c1", 32'(fifo_rd_ready), 32'd1);
        check("lat_idle_c1", 32'(out_valid), 32'd0);
        step();
        check("lat_valid_c2", 32'(out_valid), 32'd0);
        check("lat_nopop_c2", 32'(fifo_rd_ready), 32'd0);
        step();
        check("lat_valid_c3", 32'(out_valid), 32'd1);
        check("lat_data_c3", 32'(out_data), 32'hA5);
        check("lat_nopop_c3", 32'(fifo_rd_ready), 32'd0);
        step();
        check("lat_drained", 32'(out_valid), 32'd0);
        check("lat_cnt0", 32'(buf_count), 32'd0);

        // Streaming 0x00..0x0F at full rate
        for (int i = 0; i < 16; i++) begin
            push_word(DW'(i));
        end
        apply_empty();
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(i));
            step();
        end
        check("stream_end", 32'(out_valid), 32'd0);

        // Back-pressure: 10 words, consumer stalled
        out_ready = 1'b0;
        n_pops    = 0;
        for (int i = 0; i < 10; i++) begin
            push_word(DW'($urandom));
        end
        first_w = src_q[0];
        apply_empty();
        repeat (8) step();
        check("bp_pops", 32'(n_pops), 32'd4);
        check("bp_cnt", 32'(buf_count), 32'd4);
        check("bp_no_pop", 32'(fifo_rd_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", 32'(out_data), 32'(first_w));
        check("bp_src_left", 32'(src_q.size()), 32'd6);
        base      = n_beats;
        out_ready = 1'b1;
        #1;
        drain(60);
        check("bp_delivered", 32'(n_beats - base), 32'd10);
        check("bp_leftover", 32'(src_q.size() + exp_q.size()), 32'd0);

        // Simultaneous fill and drain; 27 words so far puts head at entry 3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_word(DW'($urandom));
        end
        first_w  = src_q[0];
        second_w = src_q[1];
        apply_empty();
        step();
        step();
        step();
        check("sim_cnt_before", 32'(buf_count), 32'd2);
        check("sim_data_before", 32'(out_data), 32'(first_w));
        out_ready = 1'b1;
        #1;
        step();
        check("sim_cnt_after", 32'(buf_count), 32'd2);
        check("sim_wrap_data", 32'(out_data), 32'(second_w));
        drain(20);
        check("sim_leftover", 32'(src_q.size() + exp_q.size()), 32'd0);

        // Intermittent empty with random consumer
        tog_mode   = 1'b1;
        rand_ready = 1'b1;
        base       = n_beats;
        for (int i = 0; i < 30; i++) begin
            push_word(DW'($urandom));
        end
        apply_empty();
        drain(400);
        check("int_delivered", 32'(n_beats - base), 32'd30);
        check("int_leftover", 32'(src_q.size() + exp_q.size()), 32'd0);
        check("int_err", 32'(err_unexp), 32'd0);
        tog_mode   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        #1;

        // Reset mid-stream with cnt=2 and a pop in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(DW'($urandom));
        end
        apply_empty();
        step();
        step();
        step();
        check("mid_pre_cnt", 32'(buf_count), 32'd2);
        stale        = exp_q[exp_q.size() - 1];
        rd_rst       = 1'b1;
        hold_pending = 1'b0;
        #1;
        check("mid_rst_ready", 32'(fifo_rd_ready), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_cnt", 32'(buf_count), 32'd0);
        check("mid_rst_err", 32'(err_unexp), 32'd0);
        exp_q.delete();
        step();
        rd_rst        = 1'b0;
        fifo_rd_valid = 1'b1;
        fifo_rd_data  = stale;
        out_ready     = 1'b1;
        #1;
        check("stale_err_pre", 32'(err_unexp), 32'd0);
        base = n_beats;
        step();
        check("stale_err_set", 32'(err_unexp), 32'd1);
        check("stale_not_stored", 32'(buf_count), 32'd0);
        drain(30);
        check("mid_delivered", 32'(n_beats - base), 32'd2);
        check("mid_leftover", 32'(src_q.size() + exp_q.size()), 32'd0);
        check("err_sticky", 32'(err_unexp), 32'd1);
        rd_rst = 1'b1;
        #1;
        check("err_cleared", 32'(err_unexp), 32'd0);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
